// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: decodes Op/Funct and steps IF/ID/EXE/MEM/WB,
// driving ALU operand/op selects, write strobes and next-PC select for one instruction.
module mc_ctrl #(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       EXTOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic [2:0] State
);

  localparam int unsigned CNT_W = 4;

  // ALU operation codes shared with the ALU (ctrl_encode_def.v)
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       is_r, is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw, is_iop, legal;
  logic       r_legal, r_shift, i_ext;
  logic [3:0] r_aluop, i_aluop;

  // R-type function decode
  always_comb begin
    r_aluop = ALU_NOP;
    r_legal = 1'b1;
    r_shift = 1'b0;
    case (Funct)
      FN_ADD:  r_aluop = ALU_ADD;
      FN_SUB:  r_aluop = ALU_SUB;
      FN_AND:  r_aluop = ALU_AND;
      FN_OR:   r_aluop = ALU_OR;
      FN_NOR:  r_aluop = ALU_NOR;
      FN_SLT:  r_aluop = ALU_SLT;
      FN_SLTU: r_aluop = ALU_SLTU;
      FN_SLL:  begin r_aluop = ALU_SLL; r_shift = 1'b1; end
      FN_SRL:  begin r_aluop = ALU_SRL; r_shift = 1'b1; end
      FN_JR:   r_aluop = ALU_NOP;
      default: r_legal = 1'b0;
    endcase
  end

  // I-type ALU decode; logical immediates are zero-extended
  always_comb begin
    i_aluop = ALU_NOP;
    i_ext   = 1'b1;
    is_iop  = 1'b1;
    case (Op)
      OP_ADDI: i_aluop = ALU_ADD;
      OP_SLTI: i_aluop = ALU_SLT;
      OP_ANDI: begin i_aluop = ALU_AND; i_ext = 1'b0; end
      OP_ORI:  begin i_aluop = ALU_OR;  i_ext = 1'b0; end
      default: is_iop = 1'b0;
    endcase
  end

  assign is_r   = (Op == OP_R);
  assign is_j   = (Op == OP_J);
  assign is_jal = (Op == OP_JAL);
  assign is_jr  = is_r && (Funct == FN_JR);
  assign is_beq = (Op == OP_BEQ);
  assign is_bne = (Op == OP_BNE);
  assign is_lw  = (Op == OP_LW);
  assign is_sw  = (Op == OP_SW);
  assign legal  = is_r ? r_legal
                       : (is_j | is_jal | is_beq | is_bne | is_lw | is_sw | is_iop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and per-state controls; reset forces every output low
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 1'b1;
    ALUSrcA  = 2'd0;
    ALUSrcB  = 2'd0;
    ALUOp    = ALU_NOP;
    RegDst   = 2'd0;
    WDSel    = 2'd0;
    NPCOp    = 2'd0;
    case (state_q)
      S_IF: begin
        ALUSrcB = 2'd1;
        ALUOp   = ALU_ADD;
        if (cnt_q == CNT_W'(FETCH_WAIT)) begin
          PCWrite = 1'b1;
          IRWrite = 1'b1;
          state_d = S_ID;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ID: begin
        ALUSrcB = 2'd3;
        ALUOp   = ALU_ADD;
        state_d = S_IF;
        if (!legal) begin
          state_d = S_IF;
        end else if (is_j) begin
          PCWrite = 1'b1;
          NPCOp   = 2'd2;
        end else if (is_jal) begin
          PCWrite  = 1'b1;
          NPCOp    = 2'd2;
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          WDSel    = 2'd2;
        end else if (is_jr) begin
          PCWrite = 1'b1;
          NPCOp   = 2'd3;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        state_d = S_IF;
        if (is_r) begin
          ALUSrcA = r_shift ? 2'd2 : 2'd1;
          ALUOp   = r_aluop;
          state_d = S_WB;
        end else if (is_iop) begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
          ALUOp   = i_aluop;
          EXTOp   = i_ext;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
          ALUOp   = ALU_ADD;
          state_d = S_MEM;
        end else if (is_beq || is_bne) begin
          ALUSrcA = 2'd1;
          ALUOp   = ALU_SUB;
          NPCOp   = 2'd1;
          PCWrite = is_beq ? Zero : ~Zero;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          state_d = S_WB;
        end else begin
          MemWrite = is_sw;
          state_d  = S_IF;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_r ? 2'd1 : 2'd0;
        WDSel    = is_lw ? 2'd1 : 2'd0;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      EXTOp    = 1'b0;
      ALUSrcA  = 2'd0;
      ALUSrcB  = 2'd0;
      ALUOp    = ALU_NOP;
      RegDst   = 2'd0;
      WDSel    = 2'd0;
      NPCOp    = 2'd0;
    end
  end

  assign State = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected output sequences built from the instruction
// class, compared every cycle against a FETCH_WAIT=0 and a FETCH_WAIT=2 instance.
module tb_mc_ctrl;

  localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4,
                         A_SLT = 4'd5, A_SLTU = 4'd6, A_NOR = 4'd7, A_SLL = 4'd8, A_SRL = 4'd9;

  typedef struct packed {
    logic       pcw, irw, rw, mw, ext;
    logic [1:0] srca, srcb;
    logic [3:0] aluop;
    logic [1:0] regdst, wdsel, npc;
    logic [2:0] st;
  } vec_t;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_ILL} kind_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = '0, fn = '0;
  logic zero = 1'b0;

  logic       pcw0, irw0, rw0, mw0, ext0, pcw2, irw2, rw2, mw2, ext2;
  logic [1:0] srca0, srcb0, regdst0, wdsel0, npc0, srca2, srcb2, regdst2, wdsel2, npc2;
  logic [3:0] aluop0, aluop2;
  logic [2:0] st0, st2;

  always #5 clk = ~clk;

  mc_ctrl #(.FETCH_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .Op(op), .Funct(fn), .Zero(zero),
    .PCWrite(pcw0), .IRWrite(irw0), .RegWrite(rw0), .MemWrite(mw0), .EXTOp(ext0),
    .ALUSrcA(srca0), .ALUSrcB(srcb0), .ALUOp(aluop0), .RegDst(regdst0), .WDSel(wdsel0),
    .NPCOp(npc0), .State(st0)
  );

  mc_ctrl #(.FETCH_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .Op(op), .Funct(fn), .Zero(zero),
    .PCWrite(pcw2), .IRWrite(irw2), .RegWrite(rw2), .MemWrite(mw2), .EXTOp(ext2),
    .ALUSrcA(srca2), .ALUSrcB(srcb2), .ALUOp(aluop2), .RegDst(regdst2), .WDSel(wdsel2),
    .NPCOp(npc2), .State(st2)
  );

  vec_t act0, act2, exp_v;
  vec_t exp_q[$];
  assign act0 = {pcw0, irw0, rw0, mw0, ext0, srca0, srcb0, aluop0, regdst0, wdsel0, npc0, st0};
  assign act2 = {pcw2, irw2, rw2, mw2, ext2, srca2, srcb2, aluop2, regdst2, wdsel2, npc2, st2};

  int    checks = 0, failures = 0;
  logic  chk_en = 1'b0;
  logic  sel = 1'b0;
  int    fw = 0;
  string tag = "init";
  int    cyc_idx = 0;

  logic [5:0] r_fns [0:8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                              6'b101010, 6'b101011, 6'b000000, 6'b000010};
  logic [5:0] i_ops [0:3] = '{6'b001000, 6'b001010, 6'b001100, 6'b001101};

  // Single compare process: whole output vector of the selected instance, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      vec_t a;
      a = sel ? act2 : act0;
      checks++;
      if (a !== exp_v) begin
        failures++;
        $display("FAIL %s fw=%0d cyc=%0d got=%h exp=%h (pcw,irw,rw,mw,ext,srca,srcb,aluop,regdst,wdsel,npc,st)",
                 tag, fw, cyc_idx, a, exp_v);
      end
    end
  end

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, want);
    end
  endtask

  function automatic kind_t kind(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'd0: begin
        if (f == 6'b001000) return K_JR;
        for (int i = 0; i < 9; i++) if (r_fns[i] == f) return K_R;
        return K_ILL;
      end
      6'd2:  return K_J;
      6'd3:  return K_JAL;
      6'd4, 6'd5: return K_BR;
      6'd8, 6'd10, 6'd12, 6'd13: return K_I;
      6'd35: return K_LW;
      6'd43: return K_SW;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100000: return A_ADD;
      6'b100010: return A_SUB;
      6'b100100: return A_AND;
      6'b100101: return A_OR;
      6'b100111: return A_NOR;
      6'b101010: return A_SLT;
      6'b101011: return A_SLTU;
      6'b000000: return A_SLL;
      default:   return A_SRL;
    endcase
  endfunction

  function automatic vec_t dflt(input logic [2:0] s);
    vec_t v;
    v = '0;
    v.ext = 1'b1;
    v.aluop = A_NOP;
    v.st = s;
    return v;
  endfunction

  // Expected per-cycle outputs of one whole instruction, from its class
  function automatic void build(input logic [5:0] o, input logic [5:0] f, input logic z, input int w);
    vec_t v;
    kind_t k;
    k = kind(o, f);
    exp_q.delete();
    for (int c = 0; c <= w; c++) begin
      v = dflt(3'd0); v.srcb = 2'd1; v.aluop = A_ADD;
      if (c == w) begin v.pcw = 1'b1; v.irw = 1'b1; end
      exp_q.push_back(v);
    end
    v = dflt(3'd1); v.srcb = 2'd3; v.aluop = A_ADD;
    if (k == K_J)   begin v.pcw = 1'b1; v.npc = 2'd2; end
    if (k == K_JAL) begin v.pcw = 1'b1; v.npc = 2'd2; v.rw = 1'b1; v.regdst = 2'd2; v.wdsel = 2'd2; end
    if (k == K_JR)  begin v.pcw = 1'b1; v.npc = 2'd3; end
    exp_q.push_back(v);
    if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) return;
    v = dflt(3'd2);
    case (k)
      K_R: begin v.srca = (f == 6'b000000 || f == 6'b000010) ? 2'd2 : 2'd1; v.aluop = r_alu(f); end
      K_I: begin
        v.srca = 2'd1; v.srcb = 2'd2;
        v.aluop = (o == 6'd8) ? A_ADD : (o == 6'd10) ? A_SLT : (o == 6'd12) ? A_AND : A_OR;
        v.ext = (o == 6'd8 || o == 6'd10);
      end
      K_BR: begin
        v.srca = 2'd1; v.aluop = A_SUB; v.npc = 2'd1;
        v.pcw = (o == 6'd4) ? z : ~z;
      end
      default: begin v.srca = 2'd1; v.srcb = 2'd2; v.aluop = A_ADD; end
    endcase
    exp_q.push_back(v);
    if (k == K_BR) return;
    if (k == K_LW || k == K_SW) begin
      v = dflt(3'd3); v.mw = (k == K_SW);
      exp_q.push_back(v);
      if (k == K_SW) return;
    end
    v = dflt(3'd4); v.rw = 1'b1;
    v.regdst = (k == K_R) ? 2'd1 : 2'd0;
    v.wdsel  = (k == K_LW) ? 2'd1 : 2'd0;
    exp_q.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst(input int n);
    rst = 1'b1;
    exp_v = '0;
    for (int i = 0; i < n; i++) begin cyc_idx = i; step(); end
    rst = 1'b0;
  endtask

  // Drive one instruction; abort_at >= 0 replaces that cycle onwards with a reset pulse
  task automatic run(input string nm, input logic [31:0] ir, input logic z, input int abort_at, input int rlen);
    tag = nm;
    op = ir[31:26]; fn = ir[5:0]; zero = z;
    build(op, fn, z, fw);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin do_rst(rlen); return; end
      cyc_idx = i;
      exp_v = exp_q[i];
      step();
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] ir;
    logic [5:0] o, f;
    int t;
    ir = $urandom;
    t = $urandom_range(0, 9);
    o = ir[31:26]; f = ir[5:0];
    case (t)
      0, 1, 2, 3: begin o = 6'd0; f = r_fns[$urandom_range(0, 8)]; end
      4: o = i_ops[$urandom_range(0, 3)];
      5: o = ($urandom_range(0, 1) == 0) ? 6'd35 : 6'd43;
      6: o = ($urandom_range(0, 1) == 0) ? 6'd4 : 6'd5;
      7: begin
        case ($urandom_range(0, 2))
          0: o = 6'd2;
          1: o = 6'd3;
          default: begin o = 6'd0; f = 6'b001000; end
        endcase
      end
      8: for (int g = 0; g < 64 && kind(o, f) != K_ILL; g++) o = 6'($urandom);
      default: begin
        o = 6'd0;
        for (int g = 0; g < 64 && kind(o, f) != K_ILL; g++) f = 6'($urandom);
      end
    endcase
    ir[31:26] = o; ir[5:0] = f;
    return ir;
  endfunction

  task automatic rand_phase(input int n);
    logic [31:0] ir;
    int ab;
    for (int i = 0; i < n; i++) begin
      ir = rand_ir();
      ab = -1;
      if ($urandom_range(0, 15) == 0) ab = $urandom_range(0, fw + 4);
      run("rand", ir, 1'($urandom), ab, $urandom_range(1, 2));
    end
  endtask

  initial begin
    // Hand-computed pins on the model itself
    build(6'd0, 6'b100000, 1'b0, 0);  check_int("pin_add_len", exp_q.size(), 4);
    check_int("pin_add_exe_alu", int'(exp_q[2].aluop), int'(A_ADD));
    build(6'd35, 6'd0, 1'b0, 0);      check_int("pin_lw_len", exp_q.size(), 5);
    check_int("pin_lw_wb_wdsel", int'(exp_q[4].wdsel), 1);
    build(6'd43, 6'd0, 1'b0, 0);      check_int("pin_sw_len", exp_q.size(), 4);
    build(6'd4, 6'd0, 1'b1, 0);       check_int("pin_beq_len", exp_q.size(), 3);
    check_int("pin_beq_pcw", int'(exp_q[2].pcw), 1);
    build(6'd3, 6'd16, 1'b0, 0);      check_int("pin_jal_len", exp_q.size(), 2);
    build(6'd0, 6'b100000, 1'b0, 2);  check_int("pin_add_fw2_len", exp_q.size(), 6);
    check_int("pin_fw2_if0_pcw", int'(exp_q[1].pcw), 0);

    chk_en = 1'b1;
    // Instance with FETCH_WAIT=0
    sel = 1'b0; fw = 0;
    tag = "reset"; do_rst(2);
    run("add_abort_exe", 32'h00221820, 1'b0, 2, 2);
    run("add", 32'h00221820, 1'b0, -1, 0);
    run("sll", 32'h00011080, 1'b0, -1, 0);
    run("lw", 32'h8C220004, 1'b0, -1, 0);
    run("sw", 32'hAC220004, 1'b0, -1, 0);
    run("beq_z1", 32'h10220003, 1'b1, -1, 0);
    run("beq_z0", 32'h10220003, 1'b0, -1, 0);
    run("bne_z1", 32'h14220003, 1'b1, -1, 0);
    run("bne_z0", 32'h14220003, 1'b0, -1, 0);
    run("jal", 32'h0C000010, 1'b0, -1, 0);
    run("ori", 32'h34220F0F, 1'b0, -1, 0);
    run("illegal", 32'hFC000000, 1'b0, -1, 0);
    run("jr", 32'h03E00008, 1'b0, -1, 0);
    rand_phase(300);

    // Instance with FETCH_WAIT=2
    sel = 1'b1; fw = 2;
    tag = "reset_fw2"; do_rst(2);
    run("add_fw2", 32'h00221820, 1'b0, -1, 0);
    run("add_fw2_abort_wb", 32'h00221820, 1'b0, 5, 1);
    run("lw_fw2", 32'h8C220004, 1'b0, -1, 0);
    run("add_fw2_abort_if", 32'h00221820, 1'b0, 1, 1);
    rand_phase(150);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
